// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared state type, default widths and result rounding for the MLP layer engine
// Contents:
//   DATA_W_DEF, FRAC_DEF : default data width and fractional bits
//   mlp_state_e          : layer engine FSM states
//   sat_round            : round-half-up, arithmetic shift by frac, saturate to data_w signed range
package mlp_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_DEF   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_ACT,
        S_BIAS,
        S_MAC,
        S_DRAIN
    } mlp_state_e;

    // Works on a 64-bit sign-extended accumulator so one function serves every
    // parameterisation; the caller truncates the result to data_w bits.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 data_w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (r > hi)
            sat_round = hi;
        else if (r < lo)
            sat_round = lo;
        else
            sat_round = r;
    endfunction

endpackage

// File: rtl/mlp_mac_lane.sv
// rtl/mlp_mac_lane.sv - one neuron lane: bias load, multiply-accumulate, rounded/saturated/ReLU result
// Ports:
//   aclk, areset        : clock, asynchronous active-high reset (clears accumulator)
//   i_bias_load         : load acc with bias (i_w) scaled by 2^FRAC
//   i_mac_en            : acc += i_act * i_w
//   i_relu              : clamp negative results to zero
//   i_act, i_w          : signed activation and weight/bias word
//   o_result            : rounded, saturated result of the current accumulator
module mlp_mac_lane
    import mlp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int ACC_W  = 42
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     i_bias_load,
    input  logic                     i_mac_en,
    input  logic                     i_relu,
    input  logic signed [DATA_W-1:0] i_act,
    input  logic signed [DATA_W-1:0] i_w,
    output logic        [DATA_W-1:0] o_result
);

    logic signed [ACC_W-1:0]    r_acc;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_bias_ext;
    logic signed [63:0]         w_acc_wide;
    logic        [DATA_W-1:0]   w_sr;

    assign w_prod     = i_act * i_w;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    // Bias is aligned to the product's binary point (Q.2*FRAC).
    assign w_bias_ext = {{(ACC_W-DATA_W-FRAC){i_w[DATA_W-1]}}, i_w, {FRAC{1'b0}}};
    assign w_acc_wide = {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_sr       = DATA_W'(sat_round(w_acc_wide, FRAC, DATA_W));
    assign o_result   = (i_relu && w_sr[DATA_W-1]) ? '0 : w_sr;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_acc <= '0;
        else if (i_bias_load)
            r_acc <= w_bias_ext;
        else if (i_mac_en)
            r_acc <= r_acc + w_prod_ext;
    end

endmodule

// File: rtl/mlp_layer_engine.sv
// rtl/mlp_layer_engine.sv - fully-connected layer engine, N_LANES neurons per weight-stream pass
// Ports:
//   aclk, areset                 : clock, asynchronous active-high reset
//   start, cfg_n_in/n_out/relu   : job launch and configuration (sampled in IDLE)
//   busy, done, err              : status; done/err are one-cycle pulses
//   s_axis_act_*                 : activation vector in, tlast on the final element
//   s_axis_w_*                   : bias beat then n_in weight beats per lane group
//   m_axis_*                     : one result per neuron, tlast on the layer's last neuron
module mlp_layer_engine
    import mlp_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int N_LANES = 4,
    parameter int MAX_IN  = 1024,
    parameter int ACC_W   = 2*DATA_W + $clog2(MAX_IN)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      start,
    input  logic [15:0]               cfg_n_in,
    input  logic [15:0]               cfg_n_out,
    input  logic                      cfg_relu,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    input  logic [DATA_W-1:0]         s_axis_act_tdata,
    input  logic                      s_axis_act_tvalid,
    output logic                      s_axis_act_tready,
    input  logic                      s_axis_act_tlast,
    input  logic [N_LANES*DATA_W-1:0] s_axis_w_tdata,
    input  logic                      s_axis_w_tvalid,
    output logic                      s_axis_w_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);

    localparam int AW = $clog2(MAX_IN);
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    mlp_state_e        r_state;
    logic [AW-1:0]     r_k;
    logic [AW-1:0]     r_last_k;
    logic [LW-1:0]     r_lane;
    logic [15:0]       r_base;
    logic [15:0]       r_n_out;
    logic              r_relu;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_act_tready;
    logic              r_w_tready;
    logic              r_tvalid;
    logic [DATA_W-1:0] r_act [MAX_IN];

    logic              w_act_hs;
    logic              w_w_hs;
    logic              w_m_hs;
    logic              w_bias_load;
    logic              w_mac_en;
    logic              w_last_k;
    logic              w_last_neuron;
    logic [DATA_W-1:0] w_act_rd;
    logic [DATA_W-1:0] w_lane_res [N_LANES];

    assign w_act_hs      = s_axis_act_tvalid & r_act_tready;
    assign w_w_hs        = s_axis_w_tvalid & r_w_tready;
    assign w_m_hs        = r_tvalid & m_axis_tready;
    assign w_bias_load   = w_w_hs & (r_state == S_BIAS);
    assign w_mac_en      = w_w_hs & (r_state == S_MAC);
    assign w_last_k      = (r_k == r_last_k);
    assign w_last_neuron = (17'(r_base) + 17'(r_lane) + 17'd1 == 17'(r_n_out));
    assign w_act_rd      = r_act[r_k];

    assign busy              = r_busy;
    assign done              = r_done;
    assign err               = r_err;
    assign s_axis_act_tready = r_act_tready;
    assign s_axis_w_tready   = r_w_tready;
    assign m_axis_tvalid     = r_tvalid;
    // Accumulators are frozen in DRAIN, so these stay stable under backpressure.
    assign m_axis_tdata      = r_tvalid ? w_lane_res[r_lane] : '0;
    assign m_axis_tlast      = r_tvalid & w_last_neuron;

    // Activation buffer: plain RAM, no reset.
    always_ff @(posedge aclk) begin
        if (w_act_hs)
            r_act[r_k] <= s_axis_act_tdata;
    end

    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        mlp_mac_lane #(
            .DATA_W (DATA_W),
            .FRAC   (FRAC),
            .ACC_W  (ACC_W)
        ) u_lane (
            .aclk        (aclk),
            .areset      (areset),
            .i_bias_load (w_bias_load),
            .i_mac_en    (w_mac_en),
            .i_relu      (r_relu),
            .i_act       (w_act_rd),
            .i_w         (s_axis_w_tdata[gi*DATA_W +: DATA_W]),
            .o_result    (w_lane_res[gi])
        );
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_last_k     <= '0;
            r_lane       <= '0;
            r_base       <= '0;
            r_n_out      <= '0;
            r_relu       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_act_tready <= 1'b0;
            r_w_tready   <= 1'b0;
            r_tvalid     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_n_in == 16'd0 || 32'(cfg_n_in) > MAX_IN || cfg_n_out == 16'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_last_k     <= AW'(cfg_n_in - 16'd1);
                            r_n_out      <= cfg_n_out;
                            r_relu       <= cfg_relu;
                            r_k          <= '0;
                            r_base       <= '0;
                            r_lane       <= '0;
                            r_busy       <= 1'b1;
                            r_act_tready <= 1'b1;
                            r_state      <= S_LOAD_ACT;
                        end
                    end
                end
                S_LOAD_ACT: begin
                    if (w_act_hs) begin
                        r_k <= r_k + 1'b1;
                        // tlast must coincide exactly with the final element.
                        if (w_last_k != s_axis_act_tlast) begin
                            r_err        <= 1'b1;
                            r_busy       <= 1'b0;
                            r_act_tready <= 1'b0;
                            r_state      <= S_IDLE;
                        end else if (w_last_k) begin
                            r_act_tready <= 1'b0;
                            r_w_tready   <= 1'b1;
                            r_state      <= S_BIAS;
                        end
                    end
                end
                S_BIAS: begin
                    if (w_w_hs) begin
                        r_k     <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (w_w_hs) begin
                        r_k <= r_k + 1'b1;
                        if (w_last_k) begin
                            r_w_tready <= 1'b0;
                            r_tvalid   <= 1'b1;
                            r_lane     <= '0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_m_hs) begin
                        if (w_last_neuron) begin
                            r_tvalid <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                        end else if (32'(r_lane) == N_LANES - 1) begin
                            r_tvalid   <= 1'b0;
                            r_base     <= r_base + 16'(N_LANES);
                            r_w_tready <= 1'b1;
                            r_state    <= S_BIAS;
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mlp_layer_engine.md
# mlp_layer_engine

Parametrised fully-connected layer engine for the MLP accelerator datapath. It buffers one activation vector from an AXI-Stream slave and consumes a weight/bias stream for `N_LANES` neurons in parallel. For each neuron it performs a fixed-point multiply-accumulate, rounds, saturates and optionally applies ReLU, then emits the results on an AXI-Stream master. It replaces the fixed 784-16-16-10 single-lane datapath: one instance per layer, or one instance reused layer by layer under the AXI-Lite register block.

## Interface
- `DATA_W`, 16: signed activation/weight/bias/result width.
- `FRAC`, 8: fractional bits (Q(DATA_W-FRAC).FRAC); 1.0 = 0x0100.
- `N_LANES`, 4: neurons computed in parallel.
- `MAX_IN`, 1024: activation buffer depth; `cfg_n_in` range 1..MAX_IN.
- `ACC_W`, 2*DATA_W+$clog2(MAX_IN): accumulator width.

Ports:
- `aclk` in 1: single clock.
- `areset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; latches cfg_*; honoured only in IDLE.
- `cfg_n_in` in 16: inputs per neuron.
- `cfg_n_out` in 16: neurons in layer (≥1).
- `cfg_relu` in 1: apply ReLU to results.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last output handshake.
- `err` out 1: one-cycle pulse on a config or framing error.
- `s_axis_act_tdata`/`_tvalid`/`_tready`/`_tlast`: activation stream, DATA_W wide.
- `s_axis_w_tdata`/`_tvalid`/`_tready`: weight stream, N_LANES*DATA_W wide; lane i in bits [i*DATA_W +: DATA_W].
- `m_axis_tdata`/`_tvalid`/`_tready`/`_tlast`: result stream, DATA_W wide.

## Operation
- FSM: IDLE → LOAD_ACT → BIAS → MAC → DRAIN → (BIAS for the next group | IDLE).
- IDLE:
  - `start` with cfg_n_in==0, cfg_n_in>MAX_IN or cfg_n_out==0 → `err` pulse; stay in IDLE.
  - Otherwise latch cfg_* and go to LOAD_ACT.
- LOAD_ACT:
  - Write act[k], k=0..n_in-1, one word per handshake.
  - `tlast` is required on beat n_in-1. `tlast` seen earlier → `err`, go to IDLE.
  - Beat n_in-1 without `tlast` → `err`, go to IDLE.
- BIAS:
  - One weight-stream beat carries the biases.
  - acc[i] = sign-extended bias[i] << FRAC.
- MAC:
  - n_in beats; beat k updates acc[i] += act[k]*w[i] (full 2*DATA_W product, sign-extended to ACC_W).
- Groups:
  - There are ceil(n_out/N_LANES) groups.
  - Lanes beyond n_out in the last group still consume their slot of the weight stream; the upstream pads those slots with zeros.
- DRAIN:
  - Emit lanes 0..L-1 in order, where L = min(N_LANES, remaining neurons).
  - Each result: r = (acc + 2^(FRAC-1)) >>> FRAC, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. ReLU is then applied if enabled: r<0 → 0.
  - `m_axis_tlast` = 1 only on the final neuron of the layer.
- After the last group: `done` pulse, go to IDLE. The activation buffer is retained, but a new `start` always reloads it.

## Timing
- Reset values: busy=0, done=0, err=0, all tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0. FSM=IDLE, accumulators=0.
- Reset mid-operation: abort within the reset itself; no partial output is emitted afterwards.
- `s_axis_act_tready` = 1 exactly in LOAD_ACT. `s_axis_w_tready` = 1 exactly in BIAS and MAC. All other tready are 0.
- Throughput: one activation or weight beat per cycle when valid is held high.
- Activation read is combinational from the buffer, indexed by a registered counter k.
- The accumulator register updates on the handshake cycle.
- DRAIN is entered the cycle after the last MAC handshake. `m_axis_tvalid` rises that cycle.
- Under backpressure, tdata and tlast stay stable while tvalid=1 and tready=0.
- Latency for n_in=N, one group, no stalls: start→first output valid = 1 + N + 1 + N + 1 cycles.
- `start` while busy is ignored. `err` and `done` are never asserted in the same cycle.

## Structure
- Package `mlp_pkg` holds:
  - the state enum `mlp_state_e`;
  - the default DATA_W/FRAC constants;
  - the `sat_round` function (round, shift, saturate).
- Sub-module `mlp_mac_lane`, instantiated N_LANES times via generate. Each instance holds one ACC_W accumulator and does bias load, MAC and sat_round/ReLU output.
- The top level holds the FSM, the counters (k, group, lane index) and the activation buffer.

## Test plan
- Basic MAC:
  - Stimulus: n_in=2, n_out=1, act {0x0100,0x0200}, w {0x0080,0x0040}, bias 0x0100, relu=0.
  - Required: single output 0x0200 with tlast=1, then `done` one cycle after the handshake.
- ReLU:
  - Stimulus: a result of -1.5.
  - Required: 0xFE80 with relu=0; 0x0000 with relu=1.
- Saturation:
  - Positive: n_in=4, act=w=0x7F00 → 0x7FFF.
  - Negative: w=0x8100 → 0x8000.
- Multiple groups with backpressure:
  - Stimulus: n_out=6, N_LANES=4 (2 groups); m_axis_tready toggling every cycle.
  - Required: exactly 6 beats, data stable while stalled, tlast only on beat 6.
- Error handling:
  - cfg_n_in=0 → `err` pulse, busy stays 0.
  - Early act tlast on beat 3 of 5 → `err`, return to IDLE.
  - Missing tlast on beat 5 of 5 → `err`, return to IDLE.
- Reset mid-operation:
  - Stimulus: assert areset halfway through MAC.
  - Required: all outputs take their reset values; a following normal start produces the correct results.
